// File: rtl/fetch_unit_if.sv
// Fetch-stage signal bundle: stall-control inputs, program-memory port and fetch state outputs.
// stall_cycles exists only when FETCH_STALL_CNT_EN is defined.
interface fetch_unit_if #(
    parameter int unsigned ADDR_W  = 8,
    parameter int unsigned INSTR_W = 32
);
    logic               stall;
    logic               stall_pm;
    logic [INSTR_W-1:0] pm_data;
    logic [ADDR_W-1:0]  pm_addr;
    logic [ADDR_W-1:0]  pc;
    logic [INSTR_W-1:0] ir;
    logic [5:0]         op;
    logic               halted;
`ifdef FETCH_STALL_CNT_EN
    logic [15:0]        stall_cycles;
`endif

    modport master (
        input  stall, stall_pm, pm_data,
`ifdef FETCH_STALL_CNT_EN
        output stall_cycles,
`endif
        output pm_addr, pc, ir, op, halted
    );

    modport slave (
        output stall, stall_pm, pm_data,
`ifdef FETCH_STALL_CNT_EN
        input  stall_cycles,
`endif
        input  pm_addr, pc, ir, op, halted
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC, program-memory addressing, IR, jump redirect and sticky halt.
// Optional saturating stall counter enabled by FETCH_STALL_CNT_EN.
module fetch_unit #(
    parameter int unsigned       ADDR_W  = 8,
    parameter int unsigned       INSTR_W = 32,
    parameter logic [INSTR_W-1:0] NOP    = '0,
    parameter logic [5:0]        JMP_OP  = 6'b010100,
    parameter logic [5:0]        HLT_OP  = 6'b011110
) (
    input  logic             clk,
    input  logic             reset,
    fetch_unit_if.master     bus
);
    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic [INSTR_W-1:0] ir_q, ir_d;
    logic               halted_q, halted_d;
    logic               jmp_pend_q, jmp_pend_d;
    logic [ADDR_W-1:0]  jmp_tgt_q, jmp_tgt_d;
    logic [5:0]         op;

    assign op          = ir_q[INSTR_W-1 -: 6];
    assign bus.op      = op;
    assign bus.pc      = pc_q;
    assign bus.pm_addr = pc_q;
    assign bus.ir      = ir_q;
    assign bus.halted  = halted_q;

    always_comb begin
        pc_d       = pc_q;
        ir_d       = ir_q;
        halted_d   = halted_q;
        jmp_pend_d = jmp_pend_q;
        jmp_tgt_d  = jmp_tgt_q;
        if (!halted_q) begin
            if (op == HLT_OP) begin
                halted_d = 1'b1;
            end else begin
                // Capture even while stalled so a bubble in IR cannot lose the target.
                if (op == JMP_OP) begin
                    jmp_pend_d = 1'b1;
                    jmp_tgt_d  = ir_q[ADDR_W-1:0];
                end
                if (bus.stall) begin
                    if (bus.stall_pm) ir_d = NOP;
                end else begin
                    if (op == JMP_OP) begin
                        pc_d       = ir_q[ADDR_W-1:0];
                        jmp_pend_d = 1'b0;
                    end else if (jmp_pend_q) begin
                        pc_d       = jmp_tgt_q;
                        jmp_pend_d = 1'b0;
                    end else begin
                        pc_d = pc_q + ADDR_W'(1);
                    end
                    ir_d = bus.stall_pm ? NOP : bus.pm_data;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q       <= '0;
            ir_q       <= NOP;
            halted_q   <= 1'b0;
            jmp_pend_q <= 1'b0;
            jmp_tgt_q  <= '0;
        end else begin
            pc_q       <= pc_d;
            ir_q       <= ir_d;
            halted_q   <= halted_d;
            jmp_pend_q <= jmp_pend_d;
            jmp_tgt_q  <= jmp_tgt_d;
        end
    end

`ifdef FETCH_STALL_CNT_EN
    logic [15:0] stall_cnt_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt_q <= '0;
        end else if (bus.stall && !halted_q && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_q <= stall_cnt_q + 16'd1;
        end
    end

    assign bus.stall_cycles = stall_cnt_q;
`endif
endmodule
